// File: rtl/match_result_collector.sv
// Match result collector: delays issued keys by the LUT latency, compares the
// LUT output against the expected index, counts results/mismatches and queues
// {key, match, mismatch} records in a small FIFO for readout.
module match_result_collector #(
    parameter int unsigned KEY_W   = 36,
    parameter int unsigned MATCH_W = 6,
    parameter int unsigned LAT     = 1,
    parameter int unsigned DEPTH   = 8
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       start,
    input  logic                       stop,
    input  logic                       key_valid,
    input  logic [KEY_W-1:0]           key_in,
    input  logic [MATCH_W-1:0]         exp_in,
    input  logic [MATCH_W-1:0]         match_in,
    input  logic                       rd_en,
    output logic                       rd_valid,
    output logic [KEY_W+MATCH_W:0]     rd_data,
    output logic                       empty,
    output logic                       full,
    output logic [$clog2(DEPTH):0]     count,
    output logic [15:0]                res_cnt,
    output logic [15:0]                err_cnt,
    output logic                       overflow,
    output logic                       busy,
    output logic                       done
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned DW = KEY_W + MATCH_W + 1;
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

    state_t state, state_nx;

    logic               dl_vld [LAT];
    logic [KEY_W-1:0]   dl_key [LAT];
    logic [MATCH_W-1:0] dl_exp [LAT];

    logic [DW-1:0] mem [DEPTH];
    logic [AW-1:0] wptr, rptr;

    logic any_vld, accept, take, mism, pop, push, drop;

    assign accept = key_valid && (state == S_RUN);
    assign mism   = (match_in != dl_exp[LAT-1]);
    // start flushes the delay line, so a tag exiting on that edge is discarded
    assign take   = dl_vld[LAT-1] && !start;
    assign pop    = rd_en && !empty;
    assign push   = take && (!full || pop);
    assign drop   = take && full && !pop;

    assign empty = (count == '0);
    assign full  = (count == FULL_CNT);
    assign busy  = (state == S_RUN) || (state == S_DRAIN);
    assign done  = (state == S_DONE);

    // Any valid tag still travelling through the delay line
    always_comb begin
        any_vld = 1'b0;
        for (int unsigned i = 0; i < LAT; i++) begin
            any_vld = any_vld | dl_vld[i];
        end
    end

    // Collection state register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= S_IDLE;
        else        state <= state_nx;
    end

    // Next-state logic; start wins over stop in every state
    always_comb begin
        state_nx = state;
        if (start) begin
            state_nx = S_RUN;
        end else begin
            case (state)
                S_RUN:   if (stop) state_nx = S_DRAIN;
                S_DRAIN: if (!any_vld) state_nx = S_DONE;
                default: state_nx = state;
            endcase
        end
    end

    // LUT latency delay line carrying key, expected index and valid tag
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int unsigned i = 0; i < LAT; i++) begin
                dl_vld[i] <= 1'b0;
                dl_key[i] <= '0;
                dl_exp[i] <= '0;
            end
        end else if (start) begin
            for (int unsigned i = 0; i < LAT; i++) begin
                dl_vld[i] <= 1'b0;
            end
        end else begin
            dl_vld[0] <= accept;
            dl_key[0] <= key_in;
            dl_exp[0] <= exp_in;
            for (int unsigned i = 1; i < LAT; i++) begin
                dl_vld[i] <= dl_vld[i-1];
                dl_key[i] <= dl_key[i-1];
                dl_exp[i] <= dl_exp[i-1];
            end
        end
    end

    // Result FIFO storage
    always_ff @(posedge clk) begin
        if (push) mem[wptr] <= {dl_key[LAT-1], match_in, mism};
    end

    // FIFO pointers, occupancy and registered read port
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wptr     <= '0;
            rptr     <= '0;
            count    <= '0;
            rd_valid <= 1'b0;
            rd_data  <= '0;
        end else begin
            rd_valid <= pop;
            if (pop) begin
                rd_data <= mem[rptr];
                rptr    <= rptr + 1'b1;
            end
            if (push) wptr <= wptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Saturating result/mismatch counters and sticky overflow flag
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            res_cnt  <= '0;
            err_cnt  <= '0;
            overflow <= 1'b0;
        end else if (start) begin
            res_cnt  <= '0;
            err_cnt  <= '0;
            overflow <= 1'b0;
        end else begin
            if (take && res_cnt != 16'hFFFF) res_cnt <= res_cnt + 16'd1;
            if (take && mism && err_cnt != 16'hFFFF) err_cnt <= err_cnt + 16'd1;
            if (drop) overflow <= 1'b1;
        end
    end

endmodule

// File: doc/match_result_collector.md
MATCH_RESULT_COLLECTOR -- requirements
Module: match_result_collector

Interface
REQ-001 Parameters, one per line (name, default, meaning):
- KEY_W, 36, lookup key width
- MATCH_W, 6, LUT match index width
- LAT, 1, LUT lookup latency in cycles (1..4)
- DEPTH, 8, result FIFO depth (power of 2)
REQ-002 Ports, one per line (name, direction, width, meaning):
- clk, in, 1, sole clock, rising edge
- reset, in, 1, asynchronous active-low reset
- start, in, 1, begin/restart collection run (single-cycle pulse)
- stop, in, 1, end of key stream (single-cycle pulse)
- key_valid, in, 1, key issued to LUT this cycle
- key_in, in, KEY_W, key issued to LUT
- exp_in, in, MATCH_W, expected match index for key_in
- match_in, in, MATCH_W, LUT output
- rd_en, in, 1, pop one FIFO entry
- rd_valid, out, 1, rd_data valid this cycle
- rd_data, out, KEY_W+MATCH_W+1, {key, match, mismatch}
- empty, out, 1, FIFO empty
- full, out, 1, FIFO full
- count, out, log2(DEPTH)+1, FIFO occupancy
- res_cnt, out, 16, results collected
- err_cnt, out, 16, mismatches
- overflow, out, 1, sticky: result dropped on full FIFO
- busy, out, 1, state is RUN or DRAIN
- done, out, 1, state is DONE

Function
REQ-003 FSM states IDLE, RUN, DRAIN, DONE; IDLE->RUN on start; RUN->DRAIN on stop; DRAIN->DONE when delay line holds no valid entry; DONE->RUN on start.
REQ-004 start in any state clears res_cnt, err_cnt, overflow and delay line, enters RUN; FIFO contents retained.
REQ-005 start and stop in the same cycle: start wins.
REQ-006 key_valid accepted only in RUN; ignored in IDLE, DRAIN, DONE.
REQ-007 Accepted key_in/exp_in enter a LAT-stage delay line tagged valid; match_in is sampled in the cycle the tag exits (key accepted at edge t => compared with match_in present during cycle t+LAT).
REQ-008 Mismatch bit = (match_in != exp_in of the exiting tag).
REQ-009 On each exiting tag: res_cnt +1, err_cnt +1 if mismatch; both saturate at 16'hFFFF.
REQ-010 Exiting entry written to FIFO at the same edge unless FIFO full and no pop that cycle; dropped entry sets overflow (sticky until start/reset), still counted.
REQ-011 Full FIFO with simultaneous rd_en: pop and push both occur, no drop, count unchanged.
REQ-012 rd_en with empty=1 ignored; rd_valid stays 0.
REQ-013 rd_en with empty=0: rd_data/rd_valid registered, valid the cycle after rd_en, oldest entry first; rd_valid pulses one cycle per pop.
REQ-014 Read/write pointers wrap modulo DEPTH; count = entries held, 0..DEPTH; full = (count==DEPTH), empty = (count==0).
REQ-015 Tags in flight at stop are still compared and stored in DRAIN.

Reset
REQ-016 reset low asynchronously forces: state IDLE, FIFO empty, count 0, rd_valid 0, rd_data 0, res_cnt 0, err_cnt 0, overflow 0, busy 0, done 0, delay line cleared.
REQ-017 Reset mid-run discards all in-flight tags and FIFO contents; no output activity until start after reset release.

Verification
REQ-018 LAT=1: start, 8 keys back-to-back, match_in==exp_in, stop -> count 8, res_cnt 8, err_cnt 0, DONE 2 cycles after stop, FIFO pops in issue order.
REQ-019 3 of 8 keys with match_in=exp_in^1 -> err_cnt 3; mismatch bit set on exactly those 3 rd_data entries.
REQ-020 10 keys, no pops -> count 8, full 1, overflow 1, res_cnt 10; later pop with simultaneous push while full -> count stays 8, no new drop.
REQ-021 rd_en while empty -> rd_valid 0; key_valid in IDLE -> res_cnt 0, count 0.
REQ-022 Assert reset low with 3 keys in flight and 5 FIFO entries -> all outputs at REQ-016 values immediately, no writes after release until start.
